// File: rtl/multi_debouncer.sv
// N-channel button conditioner: polarity normalisation, 2-FF sync, stability
// filter, registered press/release strobes and optional typematic auto-repeat.
module multi_debouncer #(
  parameter int unsigned     N_CH         = 4,
  parameter logic [N_CH-1:0] ACT_LOW_MASK = 4'b1111,
  parameter int unsigned     DEB_CYCLES   = 65535,
  parameter logic [N_CH-1:0] RPT_EN_MASK  = 4'b0000,
  parameter int unsigned     RPT_DELAY    = 25000000,
  parameter int unsigned     RPT_PERIOD   = 5000000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_down,
  output logic [N_CH-1:0] btn_up,
  output logic [N_CH-1:0] btn_rpt,
  output logic [N_CH-1:0] key_evt
);

  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  logic [N_CH-1:0] s0_q, s0_d;
  logic [N_CH-1:0] s1_q, s1_d;

  // Normalise to active-high before the synchroniser so reset means "released".
  always_comb begin
    s0_d = btn_in ^ ACT_LOW_MASK;
    s1_d = s0_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             down_q, down_d;
    logic             up_q, up_d;
    logic             rpt_q, rpt_d;
    logic             key_q, key_d;

    // Stability filter: any cycle of agreement restarts the count.
    always_comb begin
      cnt_d   = '0;
      state_d = state_q;
      down_d  = 1'b0;
      up_d    = 1'b0;
      if (s1_q[i] != state_q) begin
        if (cnt_q == DEB_LAST) begin
          state_d = ~state_q;
          down_d  = s1_q[i];
          up_d    = ~s1_q[i];
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    if (RPT_EN_MASK[i]) begin : g_rpt
      rpt_state_e       st_q, st_d;
      logic [RPT_W-1:0] rcnt_q, rcnt_d;

      // Typematic FSM driven by next-cycle strobes so repeats align with btn_down.
      always_comb begin
        st_d   = st_q;
        rcnt_d = rcnt_q;
        rpt_d  = 1'b0;
        case (st_q)
          ST_IDLE: begin
            if (down_d) begin
              st_d   = ST_DELAY;
              rcnt_d = '0;
            end
          end
          ST_DELAY: begin
            if (up_d) begin
              st_d   = ST_IDLE;
              rcnt_d = '0;
            end else if (rcnt_q == DLY_LAST) begin
              st_d   = ST_REPEAT;
              rcnt_d = '0;
              rpt_d  = 1'b1;
            end else begin
              rcnt_d = rcnt_q + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (up_d) begin
              st_d   = ST_IDLE;
              rcnt_d = '0;
            end else if (rcnt_q == PER_LAST) begin
              rcnt_d = '0;
              rpt_d  = 1'b1;
            end else begin
              rcnt_d = rcnt_q + RPT_W'(1);
            end
          end
          default: begin
            st_d   = ST_IDLE;
            rcnt_d = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          st_q   <= ST_IDLE;
          rcnt_q <= '0;
        end else begin
          st_q   <= st_d;
          rcnt_q <= rcnt_d;
        end
      end
    end else begin : g_norpt
      assign rpt_d = 1'b0;
    end

    assign key_d = down_d | rpt_d;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        state_q <= 1'b0;
        down_q  <= 1'b0;
        up_q    <= 1'b0;
        rpt_q   <= 1'b0;
        key_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        state_q <= state_d;
        down_q  <= down_d;
        up_q    <= up_d;
        rpt_q   <= rpt_d;
        key_q   <= key_d;
      end
    end

    assign btn_state[i] = state_q;
    assign btn_down[i]  = down_q;
    assign btn_up[i]    = up_q;
    assign btn_rpt[i]   = rpt_q;
    assign key_evt[i]   = key_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: expected strobes are queued by cycle when
// stimulus is applied and checked against the DUT every cycle.
module tb_multi_debouncer;

  localparam int unsigned N_CH       = 2;
  localparam int unsigned DEB_CYCLES = 4;
  localparam int unsigned RPT_DELAY  = 10;
  localparam int unsigned RPT_PERIOD = 3;
  // Edges from the stimulus-driving cycle to the toggle: sampling edge is the first of DEB_CYCLES+2.
  localparam int unsigned LAT        = DEB_CYCLES + 2;

  localparam int unsigned K_DOWN = 0;
  localparam int unsigned K_UP   = 1;
  localparam int unsigned K_RPT  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] btn_in;
  logic [1:0] btn_state, btn_down, btn_up, btn_rpt, key_evt;

  multi_debouncer #(
    .N_CH        (N_CH),
    .ACT_LOW_MASK(2'b01),
    .DEB_CYCLES  (DEB_CYCLES),
    .RPT_EN_MASK (2'b01),
    .RPT_DELAY   (RPT_DELAY),
    .RPT_PERIOD  (RPT_PERIOD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_in),
    .btn_state(btn_state),
    .btn_down (btn_down),
    .btn_up   (btn_up),
    .btn_rpt  (btn_rpt),
    .key_evt  (key_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
    int unsigned kind;
  } evt_t;

  evt_t        sb[$];
  int unsigned cyc;
  int unsigned n_assert;
  int unsigned n_fail;
  logic [1:0]  exp_state;

  // Insert keeping the scoreboard ordered by due cycle.
  task automatic push(input int unsigned at, input int unsigned ch, input int unsigned kind);
    evt_t e;
    int   pos;
    e.cyc  = at;
    e.ch   = ch;
    e.kind = kind;
    pos    = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].cyc > at) begin
        pos = k;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic [1:0] ed, eu, er;
    evt_t       e;
    ed = 2'b00;
    eu = 2'b00;
    er = 2'b00;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_DOWN:  ed = ed | (2'b01 << e.ch);
        K_UP:    eu = eu | (2'b01 << e.ch);
        default: er = er | (2'b01 << e.ch);
      endcase
    end
    exp_state = (exp_state | ed) & ~eu;
    chk("btn_state", btn_state, exp_state);
    chk("btn_down",  btn_down,  ed);
    chk("btn_up",    btn_up,    eu);
    chk("btn_rpt",   btn_rpt,   er);
    chk("key_evt",   key_evt,   ed | er);
  endtask

  task automatic tick(input int unsigned n);
    for (int k = 0; k < int'(n); k++) begin
      @(posedge clk);
      cyc++;
      #1;
      check_cycle();
    end
  endtask

  initial begin
    int unsigned c;
    int unsigned d;

    reset_n   = 1'b0;
    btn_in    = 2'b01;
    exp_state = 2'b00;
    cyc       = 0;
    n_assert  = 0;
    n_fail    = 0;

    // Reset and idle: everything quiet.
    tick(3);
    reset_n = 1'b1;
    tick(8);

    // Clean press/release on active-high ch1, which has no auto-repeat.
    c = cyc;
    btn_in[1] = 1'b1;
    push(c + LAT, 1, K_DOWN);
    tick(20);
    c = cyc;
    btn_in[1] = 1'b0;
    push(c + LAT, 1, K_UP);
    tick(12);

    // Bounce rejection on active-low ch0: 3-cycle glitches never qualify.
    for (int r = 0; r < 5; r++) begin
      btn_in[0] = 1'b0;
      tick(3);
      btn_in[0] = 1'b1;
      tick(3);
    end
    tick(8);

    // Auto-repeat on ch0, released so btn_up lands on the +40 repeat slot.
    c = cyc;
    btn_in[0] = 1'b0;
    d = c + LAT;
    push(d, 0, K_DOWN);
    for (int k = 0; k < 10; k++) push(d + RPT_DELAY + RPT_PERIOD * k, 0, K_RPT);
    tick(d + 40 - LAT - cyc);
    btn_in[0] = 1'b1;
    push(d + 40, 0, K_UP);
    tick(25);

    // A new press restarts the full initial delay.
    c = cyc;
    btn_in[0] = 1'b0;
    d = c + LAT;
    push(d, 0, K_DOWN);
    push(d + RPT_DELAY, 0, K_RPT);
    tick(12);
    btn_in[0] = 1'b1;
    push(d + 12, 0, K_UP);
    tick(15);

    // Simultaneous press on both channels; only ch0 repeats.
    c = cyc;
    btn_in = 2'b10;
    d = c + LAT;
    push(d, 0, K_DOWN);
    push(d, 1, K_DOWN);
    push(d + RPT_DELAY, 0, K_RPT);
    push(d + RPT_DELAY + RPT_PERIOD, 0, K_RPT);
    tick(LAT + 8);
    btn_in = 2'b01;
    push(d + 14, 0, K_UP);
    push(d + 14, 1, K_UP);
    tick(15);

    // Reset while ch1 is held: outputs clear asynchronously, no btn_up.
    c = cyc;
    btn_in[1] = 1'b1;
    push(c + LAT, 1, K_DOWN);
    tick(10);
    reset_n = 1'b0;
    #1;
    exp_state = 2'b00;
    chk("async_state", btn_state, 2'b00);
    chk("async_down",  btn_down,  2'b00);
    chk("async_up",    btn_up,    2'b00);
    chk("async_rpt",   btn_rpt,   2'b00);
    chk("async_key",   key_evt,   2'b00);
    tick(2);
    c = cyc;
    reset_n = 1'b1;
    push(c + LAT, 1, K_DOWN);
    tick(10);
    c = cyc;
    btn_in[1] = 1'b0;
    push(c + LAT, 1, K_UP);
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
